// File: rtl/axi4m_burst.sv
// AXI4 master burst engine: turns one core command into a single INCR read or
// write burst, streams beats to/from the core and reports completion with an error flag.
module axi4m_burst #(
    parameter int          AXI_ADDR_W = 32,
    parameter int          AXI_DATA_W = 32,
    parameter int          MAX_BEATS  = 16,
    parameter logic [3:0]  AXI_CACHE  = 4'b0011
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_we,
    input  logic [AXI_ADDR_W-1:0]     cmd_addr,
    input  logic [7:0]                cmd_len,
    input  logic [AXI_DATA_W-1:0]     wr_data,
    input  logic [AXI_DATA_W/8-1:0]   wr_strb,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    output logic [AXI_DATA_W-1:0]     rd_data,
    output logic                      rd_last,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic                      done_valid,
    output logic                      done_err,
    output logic [AXI_ADDR_W-1:0]     m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awlock,
    output logic [3:0]                m_axi_awcache,
    output logic [2:0]                m_axi_awprot,
    output logic [3:0]                m_axi_awqos,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [AXI_DATA_W-1:0]     m_axi_wdata,
    output logic [AXI_DATA_W/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [AXI_ADDR_W-1:0]     m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arlock,
    output logic [3:0]                m_axi_arcache,
    output logic [2:0]                m_axi_arprot,
    output logic [3:0]                m_axi_arqos,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [AXI_DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    localparam int BYTES = AXI_DATA_W / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam logic [AXI_ADDR_W-1:0] ALIGN_MASK = ~(AXI_ADDR_W'(BYTES - 1));

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,
        WDATA = 3'd2,
        WRESP = 3'd3,
        RADDR = 3'd4,
        RDATA = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t                  state_r;
    logic                    cmd_ready_r;
    logic                    awvalid_r;
    logic                    arvalid_r;
    logic                    done_valid_r;
    logic                    done_err_r;
    logic                    err_r;
    logic [7:0]              beat_cnt_r;
    logic [7:0]              len_r;
    logic [AXI_ADDR_W-1:0]   addr_r;
    logic                    reject_s;
    logic                    last_exp_s;
    logic                    r_beat_err_s;
    logic                    in_wdata_s;
    logic                    in_rdata_s;

    // Too many beats, or the last byte of the burst lands past the 4KB page.
    function automatic logic burst_reject(input logic [11:0] page_off, input logic [7:0] len);
        logic [8:0]  beats;
        logic [19:0] span;
        beats = {1'b0, len} + 9'd1;
        span  = {8'd0, page_off} + (20'(beats) * 20'(BYTES));
        return (beats > 9'(MAX_BEATS)) || (span > 20'd4096);
    endfunction

    // Command screening and per-beat read error detection.
    always_comb begin
        reject_s   = burst_reject(cmd_addr[11:0], cmd_len);
        last_exp_s = (beat_cnt_r == len_r);
        if (m_axi_rresp >= 2'b10) begin
            r_beat_err_s = 1'b1;
        end else begin
            r_beat_err_s = (m_axi_rlast != last_exp_s);
        end
    end

    assign in_wdata_s = (state_r == WDATA);
    assign in_rdata_s = (state_r == RDATA);

    // Transaction sequencer: one burst at a time, all control outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cmd_ready_r  <= 1'b0;
            awvalid_r    <= 1'b0;
            arvalid_r    <= 1'b0;
            done_valid_r <= 1'b0;
            done_err_r   <= 1'b0;
            err_r        <= 1'b0;
            beat_cnt_r   <= 8'd0;
            len_r        <= 8'd0;
            addr_r       <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_valid && cmd_ready_r) begin
                        cmd_ready_r <= 1'b0;
                        addr_r      <= cmd_addr & ALIGN_MASK;
                        len_r       <= cmd_len;
                        err_r       <= 1'b0;
                        beat_cnt_r  <= 8'd0;
                        if (reject_s) begin
                            err_r   <= 1'b1;
                            state_r <= DONE;
                        end else if (cmd_we) begin
                            awvalid_r <= 1'b1;
                            state_r   <= WADDR;
                        end else begin
                            arvalid_r <= 1'b1;
                            state_r   <= RADDR;
                        end
                    end else begin
                        cmd_ready_r <= 1'b1;
                    end
                end
                WADDR: begin
                    if (m_axi_awready) begin
                        awvalid_r <= 1'b0;
                        state_r   <= WDATA;
                    end
                end
                WDATA: begin
                    if (wr_valid && m_axi_wready) begin
                        beat_cnt_r <= beat_cnt_r + 8'd1;
                        if (last_exp_s) begin
                            state_r <= WRESP;
                        end
                    end
                end
                WRESP: begin
                    if (m_axi_bvalid) begin
                        err_r        <= err_r | (m_axi_bresp >= 2'b10);
                        done_err_r   <= err_r | (m_axi_bresp >= 2'b10);
                        done_valid_r <= 1'b1;
                        state_r      <= DONE;
                    end
                end
                RADDR: begin
                    if (m_axi_arready) begin
                        arvalid_r <= 1'b0;
                        state_r   <= RDATA;
                    end
                end
                RDATA: begin
                    if (m_axi_rvalid && rd_ready) begin
                        beat_cnt_r <= beat_cnt_r + 8'd1;
                        err_r      <= err_r | r_beat_err_s;
                        if (m_axi_rlast) begin
                            done_err_r   <= err_r | r_beat_err_s;
                            done_valid_r <= 1'b1;
                            state_r      <= DONE;
                        end
                    end
                end
                DONE: begin
                    // A rejected command arrives here without a pulse pending and raises it now.
                    if (done_valid_r) begin
                        done_valid_r <= 1'b0;
                        done_err_r   <= 1'b0;
                        cmd_ready_r  <= 1'b1;
                        state_r      <= IDLE;
                    end else begin
                        done_valid_r <= 1'b1;
                        done_err_r   <= err_r;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    cmd_ready_r  <= 1'b0;
                    awvalid_r    <= 1'b0;
                    arvalid_r    <= 1'b0;
                    done_valid_r <= 1'b0;
                    done_err_r   <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_r;
    assign done_valid    = done_valid_r;
    assign done_err      = done_err_r;

    assign m_axi_awaddr  = addr_r;
    assign m_axi_awlen   = len_r;
    assign m_axi_awsize  = 3'(SIZE);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = AXI_CACHE;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'b0000;
    assign m_axi_awvalid = awvalid_r;

    assign m_axi_wdata   = wr_data;
    assign m_axi_wstrb   = wr_strb;
    assign m_axi_wvalid  = in_wdata_s & wr_valid;
    assign m_axi_wlast   = in_wdata_s & last_exp_s;
    assign wr_ready      = in_wdata_s & m_axi_wready;
    assign m_axi_bready  = (state_r == WRESP);

    assign m_axi_araddr  = addr_r;
    assign m_axi_arlen   = len_r;
    assign m_axi_arsize  = 3'(SIZE);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = AXI_CACHE;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arqos   = 4'b0000;
    assign m_axi_arvalid = arvalid_r;

    assign rd_data       = m_axi_rdata;
    assign rd_last       = in_rdata_s & m_axi_rlast;
    assign rd_valid      = in_rdata_s & m_axi_rvalid;
    assign m_axi_rready  = in_rdata_s & rd_ready;

endmodule

// File: tb/tb_axi4m_burst.sv
// Scoreboard bench for axi4m_burst: a behavioural AXI slave plus core-side drivers,
// with expected addresses, beats and completions queued by the directed tests.
module tb_axi4m_burst;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_last, rd_valid, rd_ready;
    logic        done_valid, done_err;
    logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
    logic [7:0]  m_axi_awlen, m_axi_arlen;
    logic [2:0]  m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
    logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
    logic        m_axi_awlock, m_axi_arlock;
    logic [3:0]  m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos, m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

    always #5 clk = ~clk;

    axi4m_burst dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done_valid(done_valid), .done_err(done_err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
        .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache),
        .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    typedef struct { logic [31:0] addr; logic [7:0] len; } ax_t;
    typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } w_t;
    typedef struct { logic [31:0] data; logic last; } r_t;

    ax_t  exp_aw[$];
    ax_t  exp_ar[$];
    w_t   exp_w[$];
    r_t   exp_r[$];
    logic exp_done[$];

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int r_cnt = 0;
    int ax_cnt = 0;

    logic [1:0]  b_resp_cfg = 2'b00;
    logic [31:0] r_base = 32'h0;
    int          r_err_beat = 999;
    logic        tog_en = 1'b0;
    logic        rd_hold = 1'b0;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    function automatic logic [3:0] strb_of(input int b);
        return (b % 2 == 1) ? 4'h3 : 4'hF;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT completes a handshake.
    initial begin
        logic        aw_seen = 1'b0;
        logic        in_r = 1'b0;
        logic        aw_pend = 1'b0;
        logic [31:0] aw_hold = 32'h0;
        ax_t a;
        w_t  w;
        r_t  r;
        logic e;
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_seen = 1'b0;
                in_r    = 1'b0;
                aw_pend = 1'b0;
            end else begin
                if (m_axi_awvalid || m_axi_arvalid) ax_cnt++;
                if (aw_pend) begin
                    check("awvalid_held", m_axi_awvalid, 1);
                    check("awaddr_stable", m_axi_awaddr, aw_hold);
                end
                aw_pend = m_axi_awvalid && !m_axi_awready;
                aw_hold = m_axi_awaddr;
                if (m_axi_awvalid && m_axi_awready) begin
                    check("aw_expected", exp_aw.size() > 0, 1);
                    if (exp_aw.size() > 0) begin
                        a = exp_aw.pop_front();
                        check("awaddr", m_axi_awaddr, a.addr);
                        check("awlen", m_axi_awlen, a.len);
                        check("awsize", m_axi_awsize, 3'd2);
                        check("awburst", m_axi_awburst, 2'b01);
                        check("awcache", m_axi_awcache, 4'b0011);
                    end
                    aw_seen = 1'b1;
                end
                if (in_r) check("rready_track", m_axi_rready, rd_ready);
                if (m_axi_arvalid && m_axi_arready) begin
                    check("ar_expected", exp_ar.size() > 0, 1);
                    if (exp_ar.size() > 0) begin
                        a = exp_ar.pop_front();
                        check("araddr", m_axi_araddr, a.addr);
                        check("arlen", m_axi_arlen, a.len);
                        check("arsize", m_axi_arsize, 3'd2);
                        check("arburst", m_axi_arburst, 2'b01);
                    end
                    in_r = 1'b1;
                end
                if (m_axi_wvalid) check("w_after_aw", aw_seen, 1);
                if (m_axi_wvalid && m_axi_wready) begin
                    check("w_expected", exp_w.size() > 0, 1);
                    if (exp_w.size() > 0) begin
                        w = exp_w.pop_front();
                        check("wdata", m_axi_wdata, w.data);
                        check("wstrb", m_axi_wstrb, w.strb);
                        check("wlast", m_axi_wlast, w.last);
                    end
                end
                if (rd_valid && rd_ready) begin
                    check("r_expected", exp_r.size() > 0, 1);
                    if (exp_r.size() > 0) begin
                        r = exp_r.pop_front();
                        check("rd_data", rd_data, r.data);
                        check("rd_last", rd_last, r.last);
                    end
                    if (rd_last) in_r = 1'b0;
                    r_cnt++;
                end
                if (done_valid) begin
                    check("done_expected", exp_done.size() > 0, 1);
                    if (exp_done.size() > 0) begin
                        e = exp_done.pop_front();
                        check("done_err", done_err, e);
                    end
                    done_cnt++;
                    aw_seen = 1'b0;
                    in_r    = 1'b0;
                end
            end
        end
    end

    // Slave write response: one B beat after the wlast handshake.
    initial begin
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst && m_axi_wvalid && m_axi_wready && m_axi_wlast) begin
                @(posedge clk); #1;
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = b_resp_cfg;
                do @(negedge clk); while (!(m_axi_bready || rst));
                @(posedge clk); #1;
                m_axi_bvalid = 1'b0;
                m_axi_bresp  = 2'b00;
            end
        end
    end

    // Slave read data: streams arlen+1 beats, holding each until rready; drops out on reset.
    initial begin
        int n;
        m_axi_rvalid = 1'b0;
        m_axi_rdata  = 32'h0;
        m_axi_rresp  = 2'b00;
        m_axi_rlast  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && m_axi_arvalid && m_axi_arready) begin
                n = int'(m_axi_arlen);
                for (int b = 0; b <= n; b++) begin
                    @(posedge clk); #1;
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = r_base + 32'(b);
                    m_axi_rresp  = (b == r_err_beat) ? 2'b10 : 2'b00;
                    m_axi_rlast  = (b == n);
                    do @(negedge clk); while (!(m_axi_rready || rst));
                    if (rst) break;
                end
                @(posedge clk); #1;
                m_axi_rvalid = 1'b0;
                m_axi_rlast  = 1'b0;
                m_axi_rresp  = 2'b00;
            end
        end
    end

    // Core read-side ready: toggles every cycle when enabled, else follows rd_hold.
    initial begin
        rd_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (tog_en) rd_ready = ~rd_ready;
            else        rd_ready = rd_hold;
        end
    end

    task automatic issue_cmd(input logic we, input logic [31:0] addr, input logic [7:0] len);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_len   = len;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic feed(input int n, input logic [31:0] base);
        int t;
        for (int b = 0; b < n; b++) begin
            wr_valid = 1'b1;
            wr_data  = base + 32'(b);
            wr_strb  = strb_of(b);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!(wr_valid && wr_ready) && t < 100);
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
    endtask

    task automatic push_w(input int n, input logic [31:0] base);
        for (int b = 0; b < n; b++) exp_w.push_back('{base + 32'(b), strb_of(b), (b == n - 1)});
    endtask

    task automatic push_r(input int n, input int total, input logic [31:0] base);
        for (int b = 0; b < n; b++) exp_r.push_back('{base + 32'(b), (b == total - 1)});
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_timeout", done_cnt >= target, 1);
    endtask

    initial begin
        int d0;
        int ax0;
        int rc0;
        int n;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 32'h0; cmd_len = 8'h0;
        wr_valid = 1'b0; wr_data = 32'h0; wr_strb = 4'h0;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_awvalid", m_axi_awvalid, 0);
        check("rst_arvalid", m_axi_arvalid, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_bready", m_axi_bready, 0);
        check("rst_done", {done_valid, done_err}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("cmd_ready_after_rst", cmd_ready, 1);

        // 1: 4-beat write at 0x1000
        rd_hold = 1'b1;
        d0 = done_cnt;
        exp_aw.push_back('{32'h0000_1000, 8'd3});
        push_w(4, 32'h1111_0000);
        exp_done.push_back(1'b0);
        fork
            begin
                issue_cmd(1'b1, 32'h0000_1000, 8'd3);
                @(negedge clk);
                check("awvalid_latency", m_axi_awvalid, 1);
            end
            feed(4, 32'h1111_0000);
        join
        wait_done(d0 + 1, 100);

        // 2: single-beat read at 0x2004
        d0 = done_cnt;
        r_base = 32'hBEEF_0000;
        exp_ar.push_back('{32'h0000_2004, 8'd0});
        push_r(1, 1, r_base);
        exp_done.push_back(1'b0);
        issue_cmd(1'b0, 32'h0000_2004, 8'd0);
        wait_done(d0 + 1, 100);

        // 3: write crossing 4KB is rejected without any address phase
        d0 = done_cnt;
        ax0 = ax_cnt;
        exp_done.push_back(1'b1);
        issue_cmd(1'b1, 32'h0000_0FF8, 8'd3);
        @(negedge clk);
        check("reject_done_early", done_valid, 0);
        @(negedge clk);
        check("reject_done_pulse", {done_valid, done_err}, 2'b11);
        @(posedge clk); #1;
        wait_done(d0 + 1, 20);
        repeat (3) @(posedge clk);
        #1;
        check("reject_no_axvalid", ax_cnt, ax0);

        // 4: 8-beat read with toggling rd_ready and SLVERR on beat 5
        d0 = done_cnt;
        r_base = 32'hC0DE_0100;
        r_err_beat = 5;
        exp_ar.push_back('{32'h0000_3000, 8'd7});
        push_r(8, 8, r_base);
        exp_done.push_back(1'b1);
        tog_en = 1'b1;
        issue_cmd(1'b0, 32'h0000_3000, 8'd7);
        wait_done(d0 + 1, 200);
        tog_en = 1'b0;
        r_err_beat = 999;

        // 5: 2-beat write, AW stalled 5 cycles, B = SLVERR
        d0 = done_cnt;
        b_resp_cfg = 2'b10;
        m_axi_awready = 1'b0;
        exp_aw.push_back('{32'h0000_4010, 8'd1});
        push_w(2, 32'h5555_0000);
        exp_done.push_back(1'b1);
        fork
            issue_cmd(1'b1, 32'h0000_4010, 8'd1);
            feed(2, 32'h5555_0000);
            begin
                n = 0;
                while (!m_axi_awvalid && n < 50) begin
                    @(posedge clk); #1;
                    n++;
                end
                repeat (5) begin
                    @(posedge clk); #1;
                end
                m_axi_awready = 1'b1;
            end
        join
        wait_done(d0 + 1, 100);
        b_resp_cfg = 2'b00;

        // 6: reset in the middle of a 4-beat read
        r_base = 32'h0600_0000;
        exp_ar.push_back('{32'h0000_5000, 8'd3});
        push_r(2, 4, r_base);
        rc0 = r_cnt;
        issue_cmd(1'b0, 32'h0000_5000, 8'd3);
        n = 0;
        while (r_cnt < rc0 + 2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("mid_read_reached", r_cnt >= rc0 + 2, 1);
        rst = 1'b1;
        rd_hold = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valids", {m_axi_awvalid, m_axi_arvalid, m_axi_wvalid, rd_valid, m_axi_rready, m_axi_bready}, 6'b0);
        check("mid_rst_done", done_valid, 0);
        check("mid_rst_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        check("cmd_ready_after_mid_rst", cmd_ready, 1);
        @(posedge clk); #1;

        check("left_aw", exp_aw.size(), 0);
        check("left_ar", exp_ar.size(), 0);
        check("left_w", exp_w.size(), 0);
        check("left_r", exp_r.size(), 0);
        check("left_done", exp_done.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
